// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory address and
// captures the returned word (or a NOP on a faulted fetch) into the IF/ID register.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter int unsigned IMEM_WORDS = 4096,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_target,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc,
    output logic        o_if_id_valid,
    output logic        o_if_id_fault,
    output logic [31:0] o_fetch_count
);
    // Window end kept at 33 bits so a window touching the top of the address space cannot wrap.
    localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) << 2);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_if_pc;
    logic        r_valid;
    logic        r_fault;
    logic [31:0] r_count;

    logic        w_fault_now;
    logic        w_load;
    logic [31:0] w_pc_next;

    assign w_fault_now = (r_pc[1:0] != 2'b00) || (r_pc < IMEM_BASE) ||
                         ({1'b0, r_pc} >= IMEM_END);
    assign w_load      = !i_stall && !i_flush;
    assign w_pc_next   = i_redirect_valid ? i_redirect_target : r_pc + 32'd4;

    // A redirect seen during a stall is dropped; the ID stage holds it until the stall clears.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_pc <= RESET_PC;
        else if (!i_stall)
            r_pc <= w_pc_next;
    end

    // Flush outranks stall for IF/ID; the redirect-cycle fetch is a delay slot and loads normally.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_instr <= NOP_INSTR;
            r_if_pc <= 32'd0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else if (w_load) begin
            r_instr <= w_fault_now ? NOP_INSTR : i_imem_rdata;
            r_if_pc <= r_pc;
            r_valid <= 1'b1;
            r_fault <= w_fault_now;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_count <= 32'd0;
        else if (w_load)
            r_count <= r_count + 32'd1;
    end

    assign o_imem_addr   = r_pc;
    assign o_pc          = r_pc;
    assign o_if_id_instr = r_instr;
    assign o_if_id_pc    = r_if_pc;
    assign o_if_id_valid = r_valid;
    assign o_if_id_fault = r_fault;
    assign o_fetch_count = r_count;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the fetch stage.
module tb_instr_fetch_stage;
    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int          WORDS = 4096;

    logic        clk = 1'b0;
    logic        reset, stall, flush, rv;
    logic [31:0] rt, imem_addr, imem_rdata, pc, ii, ipc, fc;
    logic        iv, ifa;

    logic [31:0] mem [WORDS];
    int          n_vec = 0, n_err = 0;

    // model state
    logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
    logic        m_v, m_f;

    always #5 clk = ~clk;

    instr_fetch_stage dut (
        .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_flush(flush),
        .i_redirect_valid(rv), .i_redirect_target(rt),
        .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata), .o_pc(pc),
        .o_if_id_instr(ii), .o_if_id_pc(ipc), .o_if_id_valid(iv),
        .o_if_id_fault(ifa), .o_fetch_count(fc)
    );

    // Memory model: in-window words come from mem, anything else returns non-zero garbage.
    function automatic logic [31:0] rd(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (a >= BASE && a < BASE + 32'(4 * WORDS)) return mem[off[13:2]];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    assign imem_rdata = rd(imem_addr);

    function automatic logic faulty(input logic [31:0] a);
        return (a % 4 != 0) || (a < BASE) || (a >= BASE + 32'(4 * WORDS));
    endfunction

    // Drive one cycle of inputs, advance the model, then sample just after the edge.
    task automatic apply(input logic r, input logic st, input logic fl,
                         input logic rdv, input logic [31:0] tgt);
        logic f;
        @(negedge clk);
        reset = r; stall = st; flush = fl; rv = rdv; rt = tgt;
        f = faulty(m_pc);
        if (r) begin
            m_pc = BASE; m_instr = 0; m_ipc = 0; m_v = 0; m_f = 0; m_cnt = 0;
        end else begin
            if (fl) begin
                m_instr = 0; m_ipc = 0; m_v = 0; m_f = 0;
            end else if (!st) begin
                m_instr = f ? 32'h0 : rd(m_pc);
                m_ipc = m_pc; m_v = 1; m_f = f; m_cnt = m_cnt + 1;
            end
            if (!st) m_pc = rdv ? tgt : m_pc + 32'd4;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        apply(1, 0, 0, 0, 0); apply(1, 1, 1, 1, 32'h1234);
        n_vec++; if (pc !== 32'h3000) begin n_err++; $display("FAIL reset_pc got %h exp 3000", pc); end
        n_vec++; if (iv !== 1'b0 || ifa !== 1'b0) begin n_err++; $display("FAIL reset_vf got %b%b exp 00", iv, ifa); end
        n_vec++; if (ii !== 32'h0 || ipc !== 32'h0) begin n_err++; $display("FAIL reset_ifid got %h/%h exp 0/0", ii, ipc); end
        n_vec++; if (fc !== 32'h0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", fc); end
        repeat (3) apply(0, 0, 0, 0, 0);
        n_vec++; if (pc !== 32'h300C || imem_addr !== 32'h300C) begin n_err++; $display("FAIL run3_pc got %h/%h exp 300c", pc, imem_addr); end
        n_vec++; if (ipc !== 32'h3008) begin n_err++; $display("FAIL run3_ifpc got %h exp 3008", ipc); end
        n_vec++; if (fc !== 32'd3) begin n_err++; $display("FAIL run3_cnt got %0d exp 3", fc); end
        n_vec++; if (ii !== mem[2] || iv !== 1'b1) begin n_err++; $display("FAIL run3_instr got %h v%b exp %h v1", ii, iv, mem[2]); end
    endtask

    task automatic test_delay_slot;
        mem[1] = 32'h1000_0003;
        apply(1, 0, 0, 0, 0); apply(0, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 32'h3100);
        n_vec++; if (ii !== 32'h1000_0003 || ipc !== 32'h3004) begin n_err++; $display("FAIL delay_slot got %h@%h exp 10000003@3004", ii, ipc); end
        n_vec++; if (pc !== 32'h3100) begin n_err++; $display("FAIL redirect_pc got %h exp 3100", pc); end
    endtask

    task automatic test_stall;
        apply(1, 0, 0, 0, 0);
        repeat (4) apply(0, 0, 0, 0, 0);
        repeat (2) apply(0, 1, 0, 1, 32'h3200);
        n_vec++; if (pc !== 32'h3010) begin n_err++; $display("FAIL stall_pc got %h exp 3010", pc); end
        n_vec++; if (ipc !== 32'h300C || ii !== mem[3] || iv !== 1'b1) begin n_err++; $display("FAIL stall_ifid got %h@%h v%b exp %h@300c v1", ii, ipc, iv, mem[3]); end
        n_vec++; if (fc !== 32'd4) begin n_err++; $display("FAIL stall_cnt got %0d exp 4", fc); end
    endtask

    task automatic test_stall_flush;
        apply(1, 0, 0, 0, 0);
        repeat (8) apply(0, 0, 0, 0, 0);
        apply(0, 1, 1, 0, 0);
        n_vec++; if (pc !== 32'h3020) begin n_err++; $display("FAIL sflush_pc got %h exp 3020", pc); end
        n_vec++; if (iv !== 1'b0 || ii !== 32'h0 || ipc !== 32'h0) begin n_err++; $display("FAIL sflush_ifid got %h@%h v%b exp 0@0 v0", ii, ipc, iv); end
        n_vec++; if (fc !== 32'd8) begin n_err++; $display("FAIL sflush_cnt got %0d exp 8", fc); end
    endtask

    task automatic test_fault;
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 32'h3002);
        apply(0, 0, 0, 0, 0);
        n_vec++; if (ifa !== 1'b1 || ii !== 32'h0 || iv !== 1'b1 || ipc !== 32'h3002) begin n_err++; $display("FAIL misalign got f%b %h v%b @%h exp f1 0 v1 @3002", ifa, ii, iv, ipc); end
        n_vec++; if (pc !== 32'h3006) begin n_err++; $display("FAIL misalign_pc got %h exp 3006", pc); end
        apply(0, 0, 0, 1, 32'h7000);
        apply(0, 0, 0, 0, 0);
        n_vec++; if (ifa !== 1'b1 || ii !== 32'h0 || iv !== 1'b1 || ipc !== 32'h7000) begin n_err++; $display("FAIL oow got f%b %h v%b @%h exp f1 0 v1 @7000", ifa, ii, iv, ipc); end
        n_vec++; if (pc !== 32'h7004 || fc !== 32'd4) begin n_err++; $display("FAIL oow_pc got %h cnt %0d exp 7004 cnt 4", pc, fc); end
        apply(0, 0, 0, 1, 32'h2FFC);
        apply(0, 0, 0, 1, 32'h6FFC);
        n_vec++; if (ifa !== 1'b1 || ipc !== 32'h2FFC) begin n_err++; $display("FAIL below_base got f%b @%h exp f1 @2ffc", ifa, ipc); end
        apply(0, 0, 0, 1, 32'hFFFF_FFFC);
        n_vec++; if (ifa !== 1'b0 || ii !== mem[4095] || ipc !== 32'h6FFC) begin n_err++; $display("FAIL last_word got f%b %h @%h exp f0 %h @6ffc", ifa, ii, ipc, mem[4095]); end
        apply(0, 0, 0, 0, 0);
        n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL pc_wrap got %h exp 0", pc); end
    endtask

    task automatic test_reset_mid;
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 32'h3400);
        apply(0, 0, 0, 0, 0);
        apply(1, 1, 0, 1, 32'h5000);
        n_vec++; if (pc !== 32'h3000 || iv !== 1'b0 || fc !== 32'd0) begin n_err++; $display("FAIL reset_mid got pc %h v%b cnt %0d exp 3000 v0 0", pc, iv, fc); end
        apply(0, 0, 0, 0, 0);
        n_vec++; if (ipc !== 32'h3000 || ii !== mem[0] || fc !== 32'd1) begin n_err++; $display("FAIL post_reset got %h@%h cnt %0d exp %h@3000 1", ii, ipc, fc, mem[0]); end
    endtask

    task automatic test_random;
        logic [31:0] tgt;
        int          sel;
        apply(1, 0, 0, 0, 0);
        for (int k = 0; k < 600; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)      tgt = BASE + 32'($urandom_range(0, WORDS - 1)) * 4;
            else if (sel == 7) tgt = BASE + 32'($urandom_range(0, 4 * WORDS - 1));
            else if (sel == 8) tgt = $urandom;
            else               tgt = 32'hFFFF_FFF8;
            apply($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0, tgt);
            n_vec++;
            if (pc !== m_pc || imem_addr !== m_pc || ii !== m_instr || ipc !== m_ipc ||
                iv !== m_v || ifa !== m_f || fc !== m_cnt) begin
                n_err++;
                $display("FAIL rand[%0d] got pc %h ins %h@%h v%b f%b c%0d exp pc %h ins %h@%h v%b f%b c%0d",
                         k, pc, ii, ipc, iv, ifa, fc, m_pc, m_instr, m_ipc, m_v, m_f, m_cnt);
            end
        end
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0; rv = 0; rt = 0;
        for (int k = 0; k < WORDS; k++) mem[k] = $urandom | 32'h1;
        test_reset;
        test_delay_slot;
        test_stall;
        test_stall_flush;
        test_fault;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
